pmem_responder: RTL and testbench

Synthesizable physical-memory responder: the memory-side end of the cache's `pmem_*` cacheline interface.
- Accepts one line read or line write at a time and returns a single-cycle `pmem_resp` after a fixed, parameterized latency.
- Serves as the backing store under the cache in mp2-level benches and FPGA builds, and replaces the behavioral memory model.

---
 rtl/pmem_responder_if.sv | 21 ++
 rtl/pmem_responder.sv | 104 ++++++++++
 tb/tb_pmem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pmem_responder_if.sv
// Cacheline memory bus between a cache (master) and its backing store (slave).
// Address is a byte address; one 128-bit line moves per transaction.
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         pmem_error;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata, pmem_error
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata, pmem_error
    );
endinterface

// File: rtl/pmem_responder.sv
// Line-granular backing store answering the cache's pmem bus after a fixed latency.
// One transaction at a time; write wins when read and write arrive together.
module pmem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pmem_responder_if.slave    bus
);
    localparam int          LINES    = 1 << INDEX_BITS;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [INDEX_BITS-1:0]   idx_r;
    logic                    op_write_r;
    logic                    resp_r;
    logic [127:0]            rdata_r;
    logic                    error_r;

    // Contents start at zero and deliberately survive reset.
    logic [127:0]            mem_r [LINES] = '{default: 128'd0};

    logic [INDEX_BITS-1:0]   req_idx_s;
    logic                    req_s;
    logic                    accept_wr_s;
    logic                    unused_s;

    assign req_idx_s   = bus.pmem_address[INDEX_BITS+3:4];
    assign req_s       = bus.pmem_read | bus.pmem_write;
    assign accept_wr_s = (state_r == ST_IDLE) && bus.pmem_write;
    assign unused_s    = ^{bus.pmem_address[15:INDEX_BITS+4], bus.pmem_address[3:0]};

    // Write commit happens on the accepting edge, so later reads always see it.
    always_ff @(posedge clk) begin
        if (rst_n && accept_wr_s) begin
            mem_r[req_idx_s] <= bus.pmem_wdata;
        end
    end

    // Transaction sequencer with registered response, read data and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            op_write_r <= 1'b0;
            resp_r     <= 1'b0;
            rdata_r    <= 128'd0;
            error_r    <= 1'b0;
        end else begin
            resp_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        idx_r      <= req_idx_s;
                        op_write_r <= bus.pmem_write;
                        cnt_r      <= CNT_LOAD;
                        if (bus.pmem_read && bus.pmem_write) begin
                            error_r <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state_r <= ST_RESP;
                            resp_r  <= 1'b1;
                            if (!bus.pmem_write) begin
                                rdata_r <= mem_r[req_idx_s];
                            end
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r - 4'd1;
                    // Counter value 1 means the next cycle is the response cycle.
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_RESP;
                        resp_r  <= 1'b1;
                        if (!op_write_r) begin
                            rdata_r <= mem_r[idx_r];
                        end
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_resp  = resp_r;
    assign bus.pmem_rdata = rdata_r;
    assign bus.pmem_error = error_r;
endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: LATENCY=4 instance for the main plan,
// plus a LATENCY=1 instance for the single-cycle build.
module tb_pmem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    localparam logic [127:0] LINE_W = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] LINE_A = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
    localparam logic [127:0] LINE_B = 128'hBBBB_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] LINE_C = 128'hCCCC_DEAD_BEEF_0000_FFFF_1234_5678_9ABC;
    localparam logic [127:0] LINE_D = 128'hD00D_F00D_0BAD_CAFE_0000_0000_1111_2222;

    always #5 clk = ~clk;

    pmem_responder_if bus4 ();
    pmem_responder_if bus1 ();

    pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on bus4 (called at a negedge) and measure edges until resp.
    task automatic run4(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input int exp_n, input bit chain,
                        input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        bus4.pmem_read    = rd;
        bus4.pmem_write   = wr;
        bus4.pmem_address = addr;
        bus4.pmem_wdata   = wd;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus4.pmem_resp) seen = 1'b1;
        end
        check_value({tag, "_lat"}, 128'(n), 128'(exp_n));
        if (!chain) begin
            bus4.pmem_read  = 1'b0;
            bus4.pmem_write = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_value({tag, "_pulse"}, 128'(bus4.pmem_resp), 128'd0);
        end
    endtask

    // Count resp pulses on bus4 over a number of cycles.
    task automatic count_resp(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.pmem_resp) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        bit seen;

        rst_n = 1'b0;
        bus4.pmem_read = 1'b0; bus4.pmem_write = 1'b0;
        bus4.pmem_address = 16'h0000; bus4.pmem_wdata = 128'd0;
        bus1.pmem_read = 1'b0; bus1.pmem_write = 1'b0;
        bus1.pmem_address = 16'h0000; bus1.pmem_wdata = 128'd0;
        repeat (2) @(negedge clk);
        check_value("rst_resp",  128'(bus4.pmem_resp),  128'd0);
        check_value("rst_rdata", bus4.pmem_rdata,       128'd0);
        check_value("rst_error", 128'(bus4.pmem_error), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read
        run4(1'b0, 1'b1, 16'h0040, LINE_W, 4, 1'b0, "wr40");
        run4(1'b1, 1'b0, 16'h0040, 128'd0, 4, 1'b0, "rd40");
        check_value("rd40_data", bus4.pmem_rdata, LINE_W);

        // Offset bits and high-bit aliasing
        run4(1'b0, 1'b1, 16'h0010, LINE_A, 4, 1'b0, "wr10");
        run4(1'b1, 1'b0, 16'h0017, 128'd0, 4, 1'b0, "rd17");
        check_value("rd17_data", bus4.pmem_rdata, LINE_A);
        run4(1'b1, 1'b0, 16'h1010, 128'd0, 4, 1'b0, "rd1010");
        check_value("rd1010_data", bus4.pmem_rdata, LINE_A);
        run4(1'b1, 1'b0, 16'h0020, 128'd0, 4, 1'b0, "rd20");
        check_value("rd20_data", bus4.pmem_rdata, 128'd0);

        // Back-to-back writeback then fill: second resp LATENCY+1 edges later
        run4(1'b0, 1'b1, 16'h0050, LINE_B, 4, 1'b1, "wb50");
        run4(1'b1, 1'b0, 16'h0050, 128'd0, 5, 1'b0, "fill50");
        check_value("fill50_data", bus4.pmem_rdata, LINE_B);

        // Dropped request: one-cycle read still completes once
        bus4.pmem_read = 1'b1; bus4.pmem_address = 16'h0040;
        @(posedge clk);
        @(negedge clk);
        bus4.pmem_read = 1'b0;
        n = 1;
        seen = bus4.pmem_resp;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus4.pmem_resp) seen = 1'b1;
        end
        check_value("drop_lat", 128'(n), 128'd4);
        check_value("drop_data", bus4.pmem_rdata, LINE_W);
        count_resp(10, pulses);
        check_value("drop_extra", 128'(pulses), 128'd0);

        // Simultaneous read and write: write wins, error sticks
        run4(1'b1, 1'b1, 16'h0080, LINE_C, 4, 1'b0, "both80");
        check_value("both80_err", 128'(bus4.pmem_error), 128'd1);
        run4(1'b1, 1'b0, 16'h0080, 128'd0, 4, 1'b0, "rd80");
        check_value("rd80_data", bus4.pmem_rdata, LINE_C);
        check_value("rd80_err", 128'(bus4.pmem_error), 128'd1);

        // Reset two cycles into a read
        bus4.pmem_read = 1'b1; bus4.pmem_address = 16'h0040;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus4.pmem_read = 1'b0;
        #1;
        check_value("mrst_resp",  128'(bus4.pmem_resp),  128'd0);
        check_value("mrst_rdata", bus4.pmem_rdata,       128'd0);
        check_value("mrst_error", 128'(bus4.pmem_error), 128'd0);
        count_resp(2, pulses);
        rst_n = 1'b1;
        count_resp(8, n);
        check_value("mrst_noresp", 128'(pulses + n), 128'd0);
        run4(1'b1, 1'b0, 16'h0050, 128'd0, 4, 1'b0, "post50");
        check_value("post50_data", bus4.pmem_rdata, LINE_B);
        run4(1'b1, 1'b0, 16'h0080, 128'd0, 4, 1'b0, "post80");
        check_value("post80_data", bus4.pmem_rdata, LINE_C);

        // LATENCY=1 build: resp in the cycle right after acceptance
        bus1.pmem_write = 1'b1; bus1.pmem_address = 16'h0030; bus1.pmem_wdata = LINE_D;
        @(posedge clk);
        @(negedge clk);
        check_value("l1_wr_resp", 128'(bus1.pmem_resp), 128'd1);
        bus1.pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_value("l1_wr_pulse", 128'(bus1.pmem_resp), 128'd0);
        bus1.pmem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_value("l1_rd_resp", 128'(bus1.pmem_resp), 128'd1);
        check_value("l1_rd_data", bus1.pmem_rdata, LINE_D);
        bus1.pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_value("l1_rd_pulse", 128'(bus1.pmem_resp), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
